bb_burst_ctrl: RTL and testbench
================================

BB_BURST_CTRL -- requirements
Module: bb_burst_ctrl

Interface
REQ-001 Parameter IDLE_LEVEL, default 100, SHALL be the 8-bit midscale value driven on bb_out whenever no burst is playing.
REQ-002 Port clk1, input, 1 bit: SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: SHALL be the reset, synchronous and active-high.
REQ-004 Port start, input, 1 bit: SHALL be the burst request, sampled only in IDLE.
REQ-005 Port stop, input, 1 bit: SHALL be the graceful-stop request.
REQ-006 Port step, input, 2 bits: SHALL select the phase increment inc = 1<<step (1, 2, 4 or 8).
REQ-007 Port nper, input, 4 bits: SHALL give the burst length in sine periods; 0 means continuous.
REQ-008 Port busy, output, 1 bit: SHALL be high while in RUN.
REQ-009 Port done, output, 1 bit: SHALL be a one-cycle end-of-burst pulse.
REQ-010 Port bb_valid, output, 1 bit: SHALL be high when bb_out carries a sine sample.
REQ-011 Port bb_out, output, 8 bits: SHALL be the unsigned offset-binary sample, centre 100.

Function
REQ-012 States SHALL be IDLE, RUN and DONE.
REQ-013 The sine table SHALL be 16 entries, index 0..15: 100,138,171,192,200,192,171,138,100,62,29,8,0,8,29,62.
REQ-014 In IDLE with start=1 and stop=0 at edge k, the block SHALL latch step and nper, clear the 4-bit phase and period count, and enter RUN.
REQ-015 After each edge in RUN, bb_out SHALL be table[phase] with bb_valid=1, and phase SHALL advance by inc modulo 16; the first sample appears after edge k+1.
REQ-016 A period SHALL end on the sample where phase+inc overflows 16; one period is therefore 16/inc samples.
REQ-017 With nper>0, bb_valid SHALL be high for exactly nper*16/inc consecutive cycles.
REQ-018 A stop seen in RUN SHALL be latched; the burst SHALL end at the end of the current period, including when stop arrives on that period's last sample.
REQ-019 With nper=0 and no stop, RUN SHALL continue indefinitely; the period count SHALL not saturate or wrap into a termination.
REQ-020 In the cycle after the last valid sample, the block SHALL be in DONE with done=1, bb_valid=0, busy=0 and bb_out=IDLE_LEVEL, then return to IDLE.
REQ-021 start while in RUN or DONE SHALL be ignored; start and stop asserted together in IDLE SHALL be ignored, because stop has priority.
REQ-022 step and nper changes after latching SHALL have no effect until the next accepted start.
REQ-023 In IDLE, bb_out SHALL be IDLE_LEVEL and bb_valid SHALL be 0.

Reset
REQ-024 With rst=1 at an edge, the block SHALL enter IDLE regardless of state, including mid-burst without issuing done.
REQ-025 Reset values SHALL be busy=0, done=0, bb_valid=0, bb_out=IDLE_LEVEL, phase=0, period count=0 and stop latch=0.

Configuration
REQ-026 Macro BB_AMP_SCALE_EN, when defined, SHALL add input port amp_shift (2 bits, latched at start).
REQ-027 With BB_AMP_SCALE_EN defined, bb_out SHALL equal 100 + ((table[phase]-100) arithmetic-shift-right amp_shift), computed in 9-bit signed arithmetic.
REQ-028 Without BB_AMP_SCALE_EN, the amp_shift port SHALL be absent and bb_out SHALL be the raw table value.

Structure
REQ-029 Shared package bb_pkg SHALL hold the state enum, LUT depth 16, phase width 4 and the midscale constant 100.
REQ-030 The table SHALL live in a sub-module bb_sine_rom: a combinational 16x8 ROM addressed by phase.

Verification
REQ-031 Scenario: start, step=0, nper=1 -> 16 valid samples 100,138,...,8,29,62, then done=1 for one cycle with bb_out=100.
REQ-032 Scenario: step=2, nper=3 -> 12 samples repeating 100,200,100,0, then done one cycle after the 12th sample.
REQ-033 Scenario: step=1, nper=0, stop on the 3rd sample (200) -> the sequence completes with 171,100,29,0,29, then done.
REQ-034 Scenario: start during RUN, and start+stop together in IDLE -> no effect on sample count or busy.
REQ-035 Scenario: rst on the 5th sample -> after the next edge busy=0, bb_valid=0, done=0, bb_out=100; a new start plays again from 100.
REQ-036 Scenario: with BB_AMP_SCALE_EN, amp_shift=1, step=2, nper=1 -> samples 100,150,100,50.

Source files
------------

// File: rtl/bb_pkg.sv
// Shared types and constants for the baseband burst controller.
package bb_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} bb_state_e;

  localparam int         LUT_DEPTH = 16;
  localparam int         PH_W      = 4;
  localparam logic [7:0] MIDSCALE  = 8'd100;

  typedef struct packed {
    logic [1:0] step;
    logic [3:0] nper;
  } bb_cfg_t;

  function automatic logic [PH_W-1:0] ph_inc(input logic [1:0] s);
    return {{(PH_W-1){1'b0}}, 1'b1} << s;
  endfunction
endpackage

// File: rtl/bb_sine_rom.sv
// Combinational 16-entry sine table, offset-binary around midscale.
module bb_sine_rom
  import bb_pkg::*;
(
  input  logic [PH_W-1:0] addr,
  output logic [7:0]      data
);
  always_comb begin
    data = MIDSCALE;
    case (addr)
      4'd0:  data = 8'd100;
      4'd1:  data = 8'd138;
      4'd2:  data = 8'd171;
      4'd3:  data = 8'd192;
      4'd4:  data = 8'd200;
      4'd5:  data = 8'd192;
      4'd6:  data = 8'd171;
      4'd7:  data = 8'd138;
      4'd8:  data = 8'd100;
      4'd9:  data = 8'd62;
      4'd10: data = 8'd29;
      4'd11: data = 8'd8;
      4'd12: data = 8'd0;
      4'd13: data = 8'd8;
      4'd14: data = 8'd29;
      4'd15: data = 8'd62;
    endcase
  end
endmodule

// File: rtl/bb_burst_ctrl.sv
// Sine burst player: IDLE -> RUN (nper periods or until stop) -> DONE pulse.
// Optional macro BB_AMP_SCALE_EN adds amp_shift amplitude attenuation.
module bb_burst_ctrl
  import bb_pkg::*;
#(
  parameter logic [7:0] IDLE_LEVEL = 8'd100
) (
  input  logic       clk1,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] step,
  input  logic [3:0] nper,
`ifdef BB_AMP_SCALE_EN
  input  logic [1:0] amp_shift,
`endif
  output logic       busy,
  output logic       done,
  output logic       bb_valid,
  output logic [7:0] bb_out
);
  bb_state_e       state, nstate;
  bb_cfg_t         cfg;
  logic [PH_W-1:0] phase, inc;
  logic [PH_W:0]   ph_sum;
  logic [3:0]      cnt;
  logic            pend, stop_lat, finish, accept;
  logic [7:0]      rom_q, sample;

  bb_sine_rom u_rom (.addr(phase), .data(rom_q));

  assign inc    = ph_inc(cfg.step);
  assign ph_sum = {1'b0, phase} + {1'b0, inc};
  assign accept = start && !stop;
  // pend marks that the sample on bb_out closed a period; a live stop counts too
  assign finish = pend && (stop_lat || stop || (cfg.nper != 4'd0 && cnt == cfg.nper));

`ifdef BB_AMP_SCALE_EN
  logic [1:0]        amp_l;
  logic signed [8:0] dev, scaled;
  assign dev    = $signed({1'b0, rom_q}) - $signed({1'b0, MIDSCALE});
  assign scaled = (dev >>> amp_l) + $signed({1'b0, MIDSCALE});
  assign sample = scaled[7:0];

  always_ff @(posedge clk1) begin
    if (rst)                         amp_l <= 2'd0;
    else if (state == S_IDLE && accept) amp_l <= amp_shift;
  end
`else
  assign sample = rom_q;
`endif

  always_ff @(posedge clk1) begin
    if (rst) state <= S_IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      S_IDLE:  if (accept) nstate = S_RUN;
      S_RUN:   if (finish) nstate = S_DONE;
      S_DONE:  nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      cfg      <= '0;
      phase    <= '0;
      cnt      <= '0;
      pend     <= 1'b0;
      stop_lat <= 1'b0;
      bb_valid <= 1'b0;
      bb_out   <= IDLE_LEVEL;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          cfg      <= '{step: step, nper: nper};
          phase    <= '0;
          cnt      <= '0;
          pend     <= 1'b0;
          stop_lat <= 1'b0;
        end
        S_RUN: begin
          stop_lat <= stop_lat | stop;
          if (finish) begin
            bb_valid <= 1'b0;
            bb_out   <= IDLE_LEVEL;
          end else begin
            bb_valid <= 1'b1;
            bb_out   <= sample;
            phase    <= ph_sum[PH_W-1:0];
            pend     <= ph_sum[PH_W];
            // continuous mode never counts, so it cannot wrap into a stop
            if (ph_sum[PH_W] && cfg.nper != 4'd0) cnt <= cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);
endmodule

// File: tb/tb_bb_burst_ctrl.sv
// Bench for bb_burst_ctrl: per-cycle reference model plus table-driven bursts.
module tb_bb_burst_ctrl;
  logic       clk1 = 1'b0;
  logic       rst, start, stop;
  logic [1:0] step;
  logic [3:0] nper;
  logic       busy, done, bb_valid;
  logic [7:0] bb_out;
`ifdef BB_AMP_SCALE_EN
  logic [1:0] amp_shift = 2'd0;
`endif

  bb_burst_ctrl dut (
    .clk1(clk1), .rst(rst), .start(start), .stop(stop), .step(step), .nper(nper),
`ifdef BB_AMP_SCALE_EN
    .amp_shift(amp_shift),
`endif
    .busy(busy), .done(done), .bb_valid(bb_valid), .bb_out(bb_out)
  );

  always #5 clk1 = ~clk1;

  int checks = 0, errors = 0;
  int tbl[16] = '{100,138,171,192,200,192,171,138,100,62,29,8,0,8,29,62};
  localparam int BIG = 1 << 30;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  // Reference model: sample n of a burst is tbl[(n*inc)%16]; the burst length
  // is nper*L, cut to the end of the period in which stop was first seen.
  int m_mode = 0, m_n = 0, m_N = 0, m_L = 16, m_inc = 1, m_amp = 0;
  int e_busy = 0, e_done = 0, e_valid = 0, e_out = 100;
  int vcnt = 0;
  int samp_q[$];

  function automatic int samp(input int n, input int inc, input int amp);
    int v;
    v = tbl[(n * inc) % 16];
    v = 100 + ((v - 100) >>> amp);
    return v;
  endfunction

  always begin
    @(posedge clk1);
    e_valid = 0;
    e_out   = 100;
    if (rst) m_mode = 0;
    else begin
      case (m_mode)
        0: if (start && !stop) begin
          m_mode = 1;
          m_inc  = 1 << step;
          m_L    = 16 / m_inc;
          m_n    = 0;
          m_N    = (nper != 0) ? nper * m_L : BIG;
`ifdef BB_AMP_SCALE_EN
          m_amp  = amp_shift;
`else
          m_amp  = 0;
`endif
          vcnt   = 0;
          samp_q.delete();
        end
        1: begin
          if (stop) begin
            int cut;
            cut = (((m_n > 0) ? m_n - 1 : 0) / m_L + 1) * m_L;
            if (cut < m_N) m_N = cut;
          end
          if (m_n < m_N) begin
            e_valid = 1;
            e_out   = samp(m_n, m_inc, m_amp);
            m_n++;
          end else m_mode = 2;
        end
        default: m_mode = 0;
      endcase
    end
    e_busy = (m_mode == 1);
    e_done = (m_mode == 2);
    #1;
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("bb_valid", bb_valid, e_valid);
    chk("bb_out", bb_out, e_out);
    if (bb_valid) begin
      vcnt++;
      samp_q.push_back(int'(bb_out));
    end
  end

  // Start a burst, optionally poke start mid-run, pulse stop while sample
  // stop_at is on the output, and check the valid-sample count.
  task automatic run_burst(input int st, input int np, input int stop_at,
                           input int exp_cnt, input bit poke, input string nm);
    int c;
    @(negedge clk1);
    step = 2'(st); nper = 4'(np); start = 1'b1; stop = 1'b0;
    @(negedge clk1);
    start = 1'b0;
    step  = 2'($urandom);
    nper  = 4'($urandom);
    for (c = 0; c < 400 && !done; c++) begin
      stop  = bb_valid && (vcnt - 1 == stop_at);
      start = poke && ($urandom_range(0, 3) == 0);
      @(negedge clk1);
    end
    start = 1'b0; stop = 1'b0;
    chk({nm, "_done_seen"}, done, 1);
    chk({nm, "_count"}, vcnt, exp_cnt);
    @(negedge clk1);
  endtask

  typedef struct { int st; int np; int stop_at; int exp_cnt; } vec_t;
  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s33[8];
    int s36[4];
    rst = 1'b1; start = 1'b0; stop = 1'b0; step = 2'd0; nper = 4'd0;
    repeat (3) @(negedge clk1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", bb_valid, 0);
    chk("rst_out", bb_out, 100);
    rst = 1'b0;

    vecs[0] = '{0, 1, -1, 16};
    vecs[1] = '{2, 3, -1, 12};
    vecs[2] = '{1, 0,  2,  8};
    vecs[3] = '{3, 5, -1, 10};
    vecs[4] = '{0, 0, 15, 16};
    vecs[5] = '{1, 2,  0,  8};
    vecs[6] = '{2, 15, -1, 60};
    vecs[7] = '{0, 2, 16, 32};
    for (int i = 0; i < 8; i++) begin
      run_burst(vecs[i].st, vecs[i].np, vecs[i].stop_at, vecs[i].exp_cnt, 1'b0,
                $sformatf("vec%0d", i));
      if (i == 0) for (int j = 0; j < 16; j++) chk("seq_step0", samp_q[j], tbl[j]);
      if (i == 1) for (int j = 0; j < 12; j++)
        chk("seq_step2", samp_q[j], (j % 4 == 1) ? 200 : (j % 4 == 3) ? 0 : 100);
      if (i == 2) begin
        s33 = '{100, 171, 200, 171, 100, 29, 0, 29};
        for (int j = 0; j < 8; j++) chk("seq_stop", samp_q[j], s33[j]);
      end
    end

    // start pokes during RUN/DONE are ignored; start+stop in IDLE is ignored
    run_burst(0, 1, -1, 16, 1'b1, "start_in_run");
    @(negedge clk1); start = 1'b1; stop = 1'b1;
    @(negedge clk1); start = 1'b0; stop = 1'b0;
    chk("start_stop_busy", busy, 0);

    // reset mid-burst on the 5th sample: no done, back to idle
    @(negedge clk1); step = 2'd0; nper = 4'd1; start = 1'b1;
    @(negedge clk1); start = 1'b0;
    for (int c = 0; c < 20 && vcnt < 5; c++) @(negedge clk1);
    chk("pre_rst_vcnt", vcnt, 5);
    rst = 1'b1;
    @(negedge clk1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", bb_valid, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_out", bb_out, 100);
    rst = 1'b0;
    run_burst(0, 1, -1, 16, 1'b0, "after_rst");
    chk("after_rst_first", samp_q[0], 100);

`ifdef BB_AMP_SCALE_EN
    amp_shift = 2'd1;
    run_burst(2, 1, -1, 4, 1'b0, "amp");
    s36 = '{100, 150, 100, 50};
    for (int j = 0; j < 4; j++) chk("seq_amp", samp_q[j], s36[j]);
`else
    s36 = '{0, 0, 0, 0};
`endif

    for (int i = 0; i < 25; i++) begin
      int st, np, sa, L, tot;
      st = $urandom_range(0, 3);
      np = $urandom_range(0, 4);
      L  = 16 >> st;
      if (np == 0) sa = $urandom_range(0, 40);
      else sa = ($urandom_range(0, 1) == 1) ? $urandom_range(0, np * L - 1) : -1;
      tot = (np != 0) ? np * L : BIG;
      if (sa >= 0 && (sa / L + 1) * L < tot) tot = (sa / L + 1) * L;
`ifdef BB_AMP_SCALE_EN
      amp_shift = 2'($urandom);
`endif
      run_burst(st, np, sa, tot, 1'b1, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
